// File: rtl/dmem_responder.sv
// Data-port responder for the RV32I core: valid/ready requests against a word-wide
// single-port synchronous RAM. Byte and halfword stores are done as read-modify-write.
module dmem_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam logic [1:0] W_BYTE = 2'b00, W_HALF = 2'b01, W_WORD = 2'b10, W_BAD = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, RSP} state_t;

  typedef struct packed {
    logic                 write;
    logic [1:0]           width;
    logic [1:0]           lane;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0]          wdata;
  } req_t;

  state_t               state;
  req_t                 r;
  logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
  logic [31:0]          ram_q;
  logic [29:0]          off;
  logic                 err, accept, word_st;
  logic                 ram_we, ram_re;
  logic [ADDR_BITS-1:0] ram_idx;
  logic [31:0]          ram_wdata, merged, load_data;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign word_st   = req_write && (req_width == W_WORD);

  // BASE_ADDR is word aligned, so the word offset needs only the upper address bits.
  assign off = req_addr[31:2] - BASE_ADDR[31:2];
  assign err = (req_width == W_BAD)
            || (req_width == W_HALF && req_addr[0])
            || (req_width == W_WORD && req_addr[1:0] != 2'b00)
            || (req_addr < BASE_ADDR)
            || (off[29:ADDR_BITS] != '0);

  assign ram_idx   = (state == IDLE) ? off[ADDR_BITS-1:0] : r.idx;
  assign ram_wdata = (state == IDLE) ? req_wdata : merged;
  assign ram_re    = accept && !err && !word_st;
  assign ram_we    = !rst && ((accept && !err && word_st) || (state == RD && r.write));

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_idx];
  end

  // Lane merge for sub-word stores and right-aligned, zero-filled load extraction.
  always_comb begin
    merged    = ram_q;
    load_data = '0;
    case (r.width)
      W_BYTE: begin
        merged[{r.lane, 3'b000} +: 8] = r.wdata[7:0];
        load_data = {24'b0, ram_q[{r.lane, 3'b000} +: 8]};
      end
      W_HALF: begin
        merged[{r.lane[1], 4'b0000} +: 16] = r.wdata;
        load_data = {16'b0, ram_q[{r.lane[1], 4'b0000} +: 16]};
      end
      default: load_data = ram_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r          <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r <= '{write: req_write, width: req_width, lane: req_addr[1:0],
                 idx: off[ADDR_BITS-1:0], wdata: req_wdata[15:0]};
          if (err) begin
            state      <= RSP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (word_st) begin
            state      <= RSP;
            resp_valid <= 1'b1;
          end else begin
            state <= RD;
          end
        end
        RD: begin
          state      <= RSP;
          resp_valid <= 1'b1;
          if (!r.write) resp_rdata <= load_data;
        end
        RSP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load round trips, sub-word RMW, errors,
// held-valid acceptance and reset during a pending read-modify-write.
module tb_dmem_responder;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_width = 0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          n_chk = 0, n_pass = 0, resp_cnt = 0;

  dmem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_width(req_width), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (resp_valid) resp_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full request: drive, wait for acceptance, measure latency, check response.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] wd, input int elat,
                      input logic [31:0] erd, input logic eerr);
    int n, lat;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_width = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk({tag, ".ready_timeout"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk({tag, ".lat"},   32'(lat), 32'(elat));
    chk({tag, ".rdata"}, resp_rdata, erd);
    chk({tag, ".err"},   32'(resp_err), 32'(eerr));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {resp_valid, resp_err, resp_rdata[29:0]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    #2;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.resp",  {resp_valid, resp_err, resp_rdata[29:0]}, 32'd0);
    @(negedge clk); @(negedge clk); rst = 0;
    #1 chk("rst.ready_after", 32'(req_ready), 32'd1);

    // 1: word store / load
    xact("sw10", 1, 32'h10, 32'hDEADBEEF, 2'b10, 1, 32'h0, 0);
    xact("lw10", 0, 32'h10, 32'h0,        2'b10, 2, 32'hDEADBEEF, 0);
    // 2: byte store RMW
    xact("sb11", 1, 32'h11, 32'hFFFFFFAA, 2'b00, 2, 32'h0, 0);
    xact("lw10b", 0, 32'h10, 32'h0, 2'b10, 2, 32'hDEADAAEF, 0);
    xact("lb11", 0, 32'h11, 32'h0, 2'b00, 2, 32'h000000AA, 0);
    // 3: half store RMW into the upper half
    xact("sh12", 1, 32'h12, 32'hFFFF1234, 2'b01, 2, 32'h0, 0);
    xact("lh12", 0, 32'h12, 32'h0, 2'b01, 2, 32'h00001234, 0);
    xact("lh10", 0, 32'h10, 32'h0, 2'b01, 2, 32'h0000AAEF, 0);
    xact("lw10c", 0, 32'h10, 32'h0, 2'b10, 2, 32'h1234AAEF, 0);
    // 4: errors leave memory untouched
    xact("e_lw13", 0, 32'h13, 32'h0,        2'b10, 1, 32'h0, 1);
    xact("e_sh11", 1, 32'h11, 32'h00005555, 2'b01, 1, 32'h0, 1);
    xact("e_w11",  1, 32'h10, 32'hFFFFFFFF, 2'b11, 1, 32'h0, 1);
    xact("lw10d", 0, 32'h10, 32'h0, 2'b10, 2, 32'h1234AAEF, 0);

    // 5: out-of-range load, then a second request held through RSP
    c0 = resp_cnt;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h1000; req_width = 2'b10;
    @(posedge clk); #1;
    chk("oor.valid", 32'(resp_valid), 32'd1);
    chk("oor.err",   32'(resp_err),   32'd1);
    chk("oor.ready_in_rsp", 32'(req_ready), 32'd0);
    req_addr = 32'h10;
    @(posedge clk); #1;
    chk("held.idle_valid", 32'(resp_valid), 32'd0);
    chk("held.ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    chk("held.rd_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("held.valid", 32'(resp_valid), 32'd1);
    chk("held.rdata", resp_rdata, 32'h1234AAEF);
    chk("held.err",   32'(resp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("held.resp_count", 32'(resp_cnt - c0), 32'd2);

    // 6: reset during the read phase of a byte store
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'h77; req_width = 2'b00;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    #1;
    chk("mid_rst.valid", 32'(resp_valid), 32'd0);
    chk("mid_rst.ready", 32'(req_ready),  32'd0);
    repeat (2) @(posedge clk);
    #1 chk("mid_rst.valid2", {resp_valid, resp_err, resp_rdata[29:0]}, 32'd0);
    @(negedge clk); rst = 0;
    #1 chk("post_rst.ready", 32'(req_ready), 32'd1);
    xact("lw10e", 0, 32'h10, 32'h0, 2'b10, 2, 32'h1234AAEF, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
